// File: rtl/nerv_periph_pkg.sv
// Shared definitions for nerv memory-mapped peripherals: register offsets,
// STATUS bit positions and the UART transmitter state encoding.
package nerv_periph_pkg;

  localparam logic [31:0] DATA_OFS   = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_OVF_BIT   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/nerv_sync_fifo.sv
// Single-clock FIFO with one extra pointer bit to tell full from empty.
// The head entry is visible on dout without a pop; pushes while full are ignored.
module nerv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/nerv_uart_tx.sv
// Console transmitter on the nerv dmem bus: bytes written to DATA are queued
// and sent as 8N1 frames on uart_tx; STATUS reports FIFO/transmitter state.
module nerv_uart_tx
  import nerv_periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int              TW          = $clog2(CLK_DIV);
  localparam logic [TW-1:0]   BIT_LAST    = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0]   TIMER_ONE   = TW'(1);
  localparam logic [31:0]     DATA_ADDR   = BASE_ADDR + DATA_OFS;
  localparam logic [31:0]     STATUS_ADDR = BASE_ADDR + STATUS_OFS;

  // Bus handshake: dmem_valid qualifies an access and there is no ready.
  // Every access completes in its own cycle; a read's data appears on
  // dmem_rdata one cycle later and dmem_rdata is 0 in every other cycle.
  logic data_hit;
  logic status_hit;
  logic wr_any;
  logic push;
  logic ovf_set;
  logic ovf_clr;

  assign data_hit   = dmem_valid && (dmem_addr[31:2] == DATA_ADDR[31:2]);
  assign status_hit = dmem_valid && (dmem_addr[31:2] == STATUS_ADDR[31:2]);
  assign wr_any     = |dmem_wstrb;
  assign push       = data_hit && dmem_wstrb[0];

  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic [7:0] fifo_dout;

  nerv_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (dmem_wdata[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Overflow is judged on the full flag at the start of the cycle, so a
  // simultaneous pop does not rescue the byte; set beats clear.
  logic overflow;
  assign ovf_set = push && fifo_full;
  assign ovf_clr = status_hit && dmem_wstrb[0] && dmem_wdata[3];

  always_ff @(posedge clock) begin
    if (reset)        overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  tx_state_t     state;
  tx_state_t     state_d;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_d;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_d;
  logic [7:0]    shift;
  logic [7:0]    shift_d;
  logic          bit_done;

  assign bit_done = (timer == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_d;
      timer   <= timer_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state;
    timer_d   = timer;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          timer_d = BIT_LAST;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          bit_idx_d = 3'd0;
          timer_d   = BIT_LAST;
          state_d   = DATA;
        end else begin
          timer_d = timer - TIMER_ONE;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d = {1'b0, shift[7:1]};
          timer_d = BIT_LAST;
          if (bit_idx == 3'd7) state_d = STOP;
          else                 bit_idx_d = bit_idx + 3'd1;
        end else begin
          timer_d = timer - TIMER_ONE;
        end
      end
      STOP: begin
        // Chain straight into the next start bit so queued bytes go out gap-free.
        if (bit_done) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            timer_d = BIT_LAST;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer - TIMER_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    uart_tx = 1'b1;
    unique case (state)
      IDLE:    uart_tx = 1'b1;
      START:   uart_tx = 1'b0;
      DATA:    uart_tx = shift[0];
      STOP:    uart_tx = 1'b1;
      default: uart_tx = 1'b1;
    endcase
  end

  assign tx_busy = (state != IDLE) || !fifo_empty;

  logic [31:0] status_word;
  always_comb begin
    status_word                 = '0;
    status_word[STAT_FULL_BIT]  = fifo_full;
    status_word[STAT_EMPTY_BIT] = fifo_empty;
    status_word[STAT_BUSY_BIT]  = tx_busy;
    status_word[STAT_OVF_BIT]   = overflow;
  end

  always_ff @(posedge clock) begin
    if (reset)                                   dmem_rdata <= '0;
    else if ((data_hit || status_hit) && !wr_any) dmem_rdata <= status_word;
    else                                         dmem_rdata <= '0;
  end

  // Address byte offset and upper write-data bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{dmem_addr[1:0], dmem_wdata[31:8]};

endmodule

// File: doc/nerv_uart_tx.md
# nerv_uart_tx

Memory-mapped console transmitter on the nerv data-memory bus. It answers dmem writes at the console address by queuing bytes in a small FIFO and serializing them as 8N1 UART frames on a single output pin. It replaces simulation-only console printing with synthesizable hardware and sits beside data memory on the dmem bus. Its read data is OR-muxed into the core's dmem_rdata.

## Interface
- BASE_ADDR, 32'h0200_0000: word address of the DATA register. STATUS is at BASE_ADDR+4.
- CLK_DIV, 16: clock cycles per UART bit. Must be ≥2.
- FIFO_DEPTH, 8: FIFO entries. Must be a power of two, ≥2.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- dmem_valid  in  1  bus access strobe from the core.
- dmem_addr  in  32  byte address.
- dmem_wstrb  in  4  byte write strobes; 0 means a read.
- dmem_wdata  in  32  write data.
- dmem_rdata  out  32  registered read data, valid the cycle after the access; 0 when not addressed.
- uart_tx  out  1  serial output, idle high.
- tx_busy  out  1  high while a frame is on the wire or the FIFO is non-empty.

## Operation
- Address decode: a hit requires dmem_valid and dmem_addr[31:2] equal to BASE_ADDR[31:2] (DATA) or to (BASE_ADDR+4)[31:2] (STATUS). The block ignores dmem_addr[1:0].
- DATA write with wstrb[0]=1: push wdata[7:0].
  - If the FIFO is full, the byte is dropped and the sticky overflow flag is set.
  - "Full" means full at the start of the cycle. A push while full is dropped even if a pop happens in the same cycle.
  - Writes with wstrb[0]=0 have no effect.
- STATUS layout: bit0 fifo_full, bit1 fifo_empty, bit2 tx_busy, bit3 overflow, bits 31:4 zero.
- STATUS write with wstrb[0]=1 and wdata[3]=1 clears overflow.
  - If an overflow occurs in the same cycle, set wins.
- Reads of either register return STATUS in the next cycle.
- A cycle with any write strobe set returns 0 on dmem_rdata.
- In any cycle not preceded by a hit read, dmem_rdata is 0.
- Transmit FSM states:
  - IDLE: if the FIFO is non-empty, pop the byte into the shift register, drive 0, go to START.
  - START: hold 0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: drive shift[0] for CLK_DIV cycles, shift right, increment the index. After bit 7, go to STOP.
  - STOP: drive 1 for CLK_DIV cycles. At the end, if the FIFO is non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Bit timer: loads CLK_DIV-1 on entering each bit and decrements to 0. The bit ends in the cycle the timer reads 0.
- Bit index is 3 bits wide and does not wrap past 7. Exit happens on index 7.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2·FIFO_DEPTH.
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the rest are equal.

## Timing
- Reset values: uart_tx=1, tx_busy=0, dmem_rdata=0, FIFO empty, overflow=0, FSM=IDLE, timer=0.
- Reset mid-frame: uart_tx returns to 1 in the cycle after the reset edge. Queued bytes are discarded.
- Write latency: a byte accepted at edge N (FIFO empty, FSM IDLE) is popped at edge N+1. uart_tx goes low after edge N+1.
- Frame length: exactly 10·CLK_DIV cycles from the falling edge of the start bit to the end of the stop bit.
- Back-to-back bytes produce contiguous frames.
- tx_busy timing:
  - Rises after edge N.
  - Falls in the cycle after the last stop bit completes with the FIFO empty.
- Read latency: a STATUS read at edge N appears on dmem_rdata after edge N, and is cleared to 0 after edge N+1 unless read again.
- The block never stalls the bus.

## Structure
- Shared package nerv_periph_pkg holds:
  - register offsets (DATA_OFS=0, STATUS_OFS=4);
  - STATUS bit indices;
  - the tx_state_t enum (IDLE, START, DATA, STOP).
- One sub-module, nerv_sync_fifo (parameters WIDTH, DEPTH):
  - ports push/din/pop/dout/full/empty;
  - dout shows the head entry combinationally;
  - the FIFO ignores push when full.

## Test plan
All scenarios use CLK_DIV=4 and FIFO_DEPTH=4.
- Single byte: write 0x55 to 0x0200_0000.
  - uart_tx goes low after the following edge.
  - Then 40 cycles of pattern 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles.
  - tx_busy then falls.
- Back-to-back: write 0x41 then 0x42 on consecutive cycles.
  - Two frames with no idle cycle between the stop bit of 0x41 and the start bit of 0x42.
- Overflow: six consecutive writes 0x10..0x15 while idle.
  - Frames 0x10..0x14 are sent (one pops immediately and four are queued). 0x15 is dropped.
  - STATUS read returns bit3=1.
  - Writing 0x8 to 0x0200_0004 clears bit3.
- Status read: with the FIFO empty and idle, read 0x0200_0004. dmem_rdata=0x2 for one cycle, then 0.
  - A read of 0x0000_1000 returns 0.
  - A write with wstrb=4'b0010 to DATA queues nothing.
- Reset mid-frame: assert reset for 1 cycle during DATA bit 3.
  - uart_tx=1 and tx_busy=0 after the next edge.
  - STATUS=0x2.
  - No residual frame follows.
